mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1: cycles from the mem_en cycle to the cycle in which mem_rdata is valid; the legal range is 1-4.
REQ-002 Parameter MAX_DM_STREAK, default 2: the maximum number of consecutive data grants while if_req is pending.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  in  32  fetch byte address, stable while if_req is high.
REQ-007 dm_req  in  1  data-stage request, held until dm_ack.
REQ-008 dm_we  in  1  1 = write and 0 = read; stable with dm_req.
REQ-009 dm_addr  in  32  data address.
REQ-010 dm_wdata  in  32  data to write.
REQ-011 mem_rdata  in  32  read data from the shared single-port memory.
REQ-012 mem_en  out  1  memory access strobe.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  32  memory address.
REQ-015 mem_wdata  out  32  memory write data.
REQ-016 if_ack  out  1  one-cycle completion pulse for the fetch request.
REQ-017 if_rdata  out  32  fetched word, valid when if_ack is high and held until the next fetch completes.
REQ-018 dm_ack  out  1  one-cycle completion pulse for the data request.
REQ-019 dm_rdata  out  32  load data, updated only on read completion and held otherwise.
REQ-020 if_stall  out  1  combinational: if_req & ~if_ack.
REQ-021 dm_stall  out  1  combinational: dm_req & ~dm_ack.

Function
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-023 Requests SHALL be sampled only in IDLE; if any request is present, the arbiter grants one at the end of the IDLE cycle and goes to ISSUE.
REQ-024 Priority SHALL be data over fetch, except that the fetch is granted when if_req=1 and dm_streak==MAX_DM_STREAK.
REQ-025 dm_streak SHALL increment (saturating) on each data grant made while if_req=1, and SHALL clear on any fetch grant and on any grant made while if_req=0.
REQ-026 At grant, the arbiter SHALL register the requester identity, address, write enable and write data; later changes on the request inputs SHALL NOT affect the transaction in flight.
REQ-027 In ISSUE, for exactly one cycle: mem_en=1, mem_addr equals the latched address, mem_we is 1 only for a data write, and mem_wdata equals the latched dm_wdata.
REQ-028 In all other states mem_en and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-029 A write SHALL go ISSUE -> RESP; a read SHALL go ISSUE -> WAIT, with the counter loaded to LATENCY.
REQ-030 WAIT SHALL decrement the counter each cycle; in the cycle where the counter equals 1, the arbiter captures mem_rdata into the granted requester's rdata register and goes to RESP.
REQ-031 In RESP, for exactly one cycle, the granted requester's ack SHALL be 1; the FSM then returns to IDLE.
REQ-032 Read latency SHALL be as follows: for a request sampled in IDLE cycle T, the ack arrives in cycle T+2+LATENCY.
REQ-033 Write latency: a write request sampled in IDLE cycle T SHALL be acked in cycle T+2.
REQ-034 A requester may keep req high through RESP to issue a back-to-back request with new address and data; that request is arbitrated in the following IDLE cycle.
REQ-035 Both requests arriving in the same IDLE cycle SHALL be resolved per REQ-024; the loser is served in a later IDLE cycle with its stall output held high.
REQ-036 Requests that drop before being granted SHALL be ignored without side effects.
REQ-037 Ack SHALL never be asserted to a requester that was not granted, and never to both requesters in the same cycle.

Reset
REQ-038 With rst high at a clock edge, the following SHALL be set on that edge, overriding any state: state=IDLE, counter=0, dm_streak=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0.
REQ-039 Reset in ISSUE, WAIT or RESP SHALL abort the transaction: no ack is issued afterwards, and the transaction is not replayed after reset.

Verification
REQ-040 Fetch read, LATENCY=1: if_req=1 and if_addr=0x0000_0010 in cycle 0, mem_rdata=0x2002_0005 in cycle 2 -> mem_en=1 and mem_addr=0x10 in cycle 1; if_ack=1 and if_rdata=0x2002_0005 in cycle 3; if_stall=1 in cycles 0-2.
REQ-041 Contention, LATENCY=1: if_req and dm_req (read, 0x100) both high in cycle 0 -> mem_addr=0x100 in cycle 1 and dm_ack in cycle 3; IDLE in cycle 4 grants the fetch, mem_en in cycle 5, if_ack in cycle 7.
REQ-042 Data write: dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0xDEAD_BEEF in cycle 0 -> mem_en=mem_we=1 with that address and data in cycle 1; dm_ack in cycle 2; dm_rdata unchanged.
REQ-043 Fairness: dm_req held continuously (back-to-back) with if_req=1 and MAX_DM_STREAK=2 -> grants in the order data, data, fetch, data, data, fetch.
REQ-044 Reset mid-read, LATENCY=3: rst=1 in the second WAIT cycle -> state IDLE after that edge; no ack in any later cycle; mem_en=0; the pending if_req is re-arbitrated after rst deasserts.
REQ-045 LATENCY=3 read: a request sampled in cycle 0 -> mem_en in cycle 1, mem_rdata captured in cycle 4, ack in cycle 5.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for one shared single-port memory between instruction fetch and the data stage.
// Data wins by default; fetch is forced through after MAX_DM_STREAK back-to-back data grants.
module mem_arbiter #(
   parameter int unsigned LATENCY       = 1,
   parameter int unsigned MAX_DM_STREAK = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        if_stall,
   output logic        dm_stall
);

   localparam int unsigned        StreakW   = $clog2(MAX_DM_STREAK + 2);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DM_STREAK);
   localparam logic [2:0]         CntInit   = 3'(LATENCY);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e             state_q;
   logic [2:0]         cnt_q;
   logic [StreakW-1:0] dm_streak_q;
   logic               gnt_dm_q;
   logic               gnt_we_q;
   logic               dm_win;

   // Fetch takes the slot only once data has had its full streak while fetch waited.
   assign dm_win   = dm_req & ~(if_req & (dm_streak_q == StreakMax));
   assign if_stall = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         dm_streak_q <= '0;
         gnt_dm_q    <= 1'b0;
         gnt_we_q    <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_ack      <= 1'b0;
         dm_ack      <= 1'b0;
         if_rdata    <= '0;
         dm_rdata    <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (if_req || dm_req) begin
                  state_q   <= StIssue;
                  gnt_dm_q  <= dm_win;
                  gnt_we_q  <= dm_win & dm_we;
                  mem_en    <= 1'b1;
                  mem_we    <= dm_win & dm_we;
                  mem_addr  <= dm_win ? dm_addr : if_addr;
                  mem_wdata <= dm_wdata;
                  if (dm_win && if_req) begin
                     if (dm_streak_q != StreakMax) dm_streak_q <= dm_streak_q + 1'b1;
                  end else begin
                     dm_streak_q <= '0;
                  end
               end
            end
            StIssue: begin
               if (gnt_we_q) begin
                  state_q <= StResp;
                  dm_ack  <= 1'b1;
               end else begin
                  state_q <= StWait;
                  cnt_q   <= CntInit;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_q <= StResp;
                  if (gnt_dm_q) begin
                     dm_rdata <= mem_rdata;
                     dm_ack   <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end
               end
            end
            StResp: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at LATENCY=1 and one at LATENCY=3 share the stimulus,
// each with its own memory model; acks are matched against a queue of expected completions.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;

   logic [31:0] m1_rdata, m1_addr, m1_wdata, if1_rdata, dm1_rdata;
   logic        m1_en, m1_we, if1_ack, dm1_ack, if1_stall, dm1_stall;
   logic [31:0] m3_rdata, m3_addr, m3_wdata, if3_rdata, dm3_rdata;
   logic        m3_en, m3_we, if3_ack, dm3_ack, if3_stall, dm3_stall;

   typedef struct {
      bit          is_dm;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t sb1[$];
   exp_t sb3[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [31:0] f_mem(input logic [31:0] a);
      return a ^ 32'h2002_0015;
   endfunction

   // Memory model: read data valid only LATENCY cycles after the mem_en cycle.
   logic [3:0] sh1 = '0;
   logic [3:0] sh3 = '0;
   always @(posedge clk) begin
      sh1 <= {sh1[2:0], m1_en};
      sh3 <= {sh3[2:0], m3_en};
   end
   assign m1_rdata = (sh1[0] === 1'b1) ? f_mem(m1_addr) : 32'hBAD0_BAD0;
   assign m3_rdata = (sh3[2] === 1'b1) ? f_mem(m3_addr) : 32'hBAD0_BAD0;

   mem_arbiter #(.LATENCY(1), .MAX_DM_STREAK(2)) u_dut1 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .dm_req(dm_req),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .mem_rdata(m1_rdata),
      .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .if_ack(if1_ack), .if_rdata(if1_rdata), .dm_ack(dm1_ack), .dm_rdata(dm1_rdata),
      .if_stall(if1_stall), .dm_stall(dm1_stall)
   );

   mem_arbiter #(.LATENCY(3), .MAX_DM_STREAK(2)) u_dut3 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .dm_req(dm_req),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .mem_rdata(m3_rdata),
      .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
      .if_ack(if3_ack), .if_rdata(if3_rdata), .dm_ack(dm3_ack), .dm_rdata(dm3_rdata),
      .if_stall(if3_stall), .dm_stall(dm3_stall)
   );

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b1;
      dm_addr = 32'h88; dm_wdata = 32'h1234_5678;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({m1_en, m1_we, if1_ack, dm1_ack, m3_en, m3_we, if3_ack, dm3_ack} !== 8'h00)
         $display("FAIL reset_ctrl: got %b%b%b%b %b%b%b%b, expected all 0",
                  m1_en, m1_we, if1_ack, dm1_ack, m3_en, m3_we, if3_ack, dm3_ack);
      else n_pass++;
      n_checks++;
      if ({m1_addr, m1_wdata, m3_addr, m3_wdata} !== 128'h0)
         $display("FAIL reset_mem_bus: got addr %h/%h wdata %h/%h, expected 0",
                  m1_addr, m3_addr, m1_wdata, m3_wdata);
      else n_pass++;
      n_checks++;
      if ({if1_rdata, dm1_rdata, if3_rdata, dm3_rdata} !== 128'h0)
         $display("FAIL reset_rdata: got %h %h %h %h, expected 0",
                  if1_rdata, dm1_rdata, if3_rdata, dm3_rdata);
      else n_pass++;
      n_checks++;
      if ({if1_stall, dm1_stall, if3_stall, dm3_stall} !== 4'b1111)
         $display("FAIL reset_stall: got %b%b%b%b, expected 1111",
                  if1_stall, dm1_stall, if3_stall, dm3_stall);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({m1_en, m3_en} !== 2'b00)
         $display("FAIL reset_idle: got mem_en %b%b, expected 00", m1_en, m3_en);
      else n_pass++;
   endtask

   task automatic test_fetch_read();
      exp_t e;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            if_req = 1'b1; if_addr = 32'h0000_0010;
            sb1.push_back('{1'b0, 32'h2002_0005, 3});
         end
         if (c == 4) if_req = 1'b0;
         @(negedge clk);
         n_checks++;
         if (m1_en !== (c == 1))
            $display("FAIL fetch_mem_en c%0d: got %b want %b", c, m1_en, c == 1);
         else n_pass++;
         if (c == 1) begin
            n_checks++;
            if (m1_addr !== 32'h10) $display("FAIL fetch_mem_addr: got %h want 10", m1_addr);
            else n_pass++;
         end
         n_checks++;
         if (if1_stall !== (c <= 2))
            $display("FAIL fetch_stall c%0d: got %b want %b", c, if1_stall, c <= 2);
         else n_pass++;
         if (if1_ack || dm1_ack) begin
            n_checks++;
            if (sb1.size() == 0) $display("FAIL fetch_ack unexpected at c%0d", c);
            else begin
               e = sb1.pop_front();
               if ((dm1_ack !== e.is_dm) || (if1_ack === dm1_ack) || (c != e.cyc) ||
                   ((e.is_dm ? dm1_rdata : if1_rdata) !== e.rdata))
                  $display("FAIL fetch_ack: got dm=%b if=%b c%0d data %h/%h, want dm=%b c%0d %h",
                           dm1_ack, if1_ack, c, dm1_rdata, if1_rdata, e.is_dm, e.cyc, e.rdata);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (if1_rdata !== 32'h2002_0005) $display("FAIL fetch_hold: got %h want 20020005", if1_rdata);
      else n_pass++;
      n_checks++;
      if (sb1.size() != 0) begin
         $display("FAIL fetch_missing_ack: got %0d pending, want 0", sb1.size());
         sb1.delete();
      end else n_pass++;
   endtask

   task automatic test_contention();
      exp_t e;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            if_req = 1'b1; if_addr = 32'h40;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
            sb1.push_back('{1'b1, f_mem(32'h100), 3});
            sb1.push_back('{1'b0, f_mem(32'h40), 7});
         end
         if (c == 4) dm_req = 1'b0;
         if (c == 8) if_req = 1'b0;
         @(negedge clk);
         n_checks++;
         if (m1_en !== (c == 1 || c == 5))
            $display("FAIL cont_mem_en c%0d: got %b", c, m1_en);
         else n_pass++;
         if (c == 1 || c == 5) begin
            n_checks++;
            if (m1_addr !== ((c == 1) ? 32'h100 : 32'h40))
               $display("FAIL cont_mem_addr c%0d: got %h", c, m1_addr);
            else n_pass++;
         end
         n_checks++;
         if ({if1_stall, dm1_stall} !== {(c <= 6), (c <= 2)})
            $display("FAIL cont_stall c%0d: got %b%b want %b%b", c, if1_stall, dm1_stall,
                     c <= 6, c <= 2);
         else n_pass++;
         if (if1_ack || dm1_ack) begin
            n_checks++;
            if (sb1.size() == 0) $display("FAIL cont_ack unexpected at c%0d", c);
            else begin
               e = sb1.pop_front();
               if ((dm1_ack !== e.is_dm) || (if1_ack === dm1_ack) || (c != e.cyc) ||
                   ((e.is_dm ? dm1_rdata : if1_rdata) !== e.rdata))
                  $display("FAIL cont_ack: got dm=%b if=%b c%0d data %h/%h, want dm=%b c%0d %h",
                           dm1_ack, if1_ack, c, dm1_rdata, if1_rdata, e.is_dm, e.cyc, e.rdata);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (sb1.size() != 0) begin
         $display("FAIL cont_missing_ack: got %0d pending, want 0", sb1.size());
         sb1.delete();
      end else n_pass++;
   endtask

   // Runs straight after contention so dm_rdata holds a prior load value.
   task automatic test_write();
      exp_t e;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
            sb1.push_back('{1'b1, f_mem(32'h100), 2});
         end
         if (c == 3) begin
            dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0;
         end
         @(negedge clk);
         n_checks++;
         if ({m1_en, m1_we} !== {(c == 1), (c == 1)})
            $display("FAIL write_en_we c%0d: got %b%b", c, m1_en, m1_we);
         else n_pass++;
         if (c == 1 || c == 2) begin
            n_checks++;
            if ({m1_addr, m1_wdata} !== {32'h200, 32'hDEAD_BEEF})
               $display("FAIL write_bus c%0d: got %h %h want 200 deadbeef", c, m1_addr, m1_wdata);
            else n_pass++;
         end
         if (if1_ack || dm1_ack) begin
            n_checks++;
            if (sb1.size() == 0) $display("FAIL write_ack unexpected at c%0d", c);
            else begin
               e = sb1.pop_front();
               if ((dm1_ack !== e.is_dm) || (if1_ack === dm1_ack) || (c != e.cyc) ||
                   ((e.is_dm ? dm1_rdata : if1_rdata) !== e.rdata))
                  $display("FAIL write_ack: got dm=%b if=%b c%0d data %h/%h, want dm=%b c%0d %h",
                           dm1_ack, if1_ack, c, dm1_rdata, if1_rdata, e.is_dm, e.cyc, e.rdata);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (sb1.size() != 0) begin
         $display("FAIL write_missing_ack: got %0d pending, want 0", sb1.size());
         sb1.delete();
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   dn = 0;
      int   fn = 0;
      do_reset();
      for (int c = 0; c < 28; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
            sb1.push_back('{1'b1, f_mem(32'h1000), 3});
            sb1.push_back('{1'b1, f_mem(32'h1004), 7});
            sb1.push_back('{1'b0, f_mem(32'h2000), 11});
            sb1.push_back('{1'b1, f_mem(32'h1008), 15});
            sb1.push_back('{1'b1, f_mem(32'h100C), 19});
            sb1.push_back('{1'b0, f_mem(32'h2004), 23});
         end
         dm_addr = 32'h1000 + 32'(4 * dn);
         if_addr = 32'h2000 + 32'(4 * fn);
         if (c == 24) begin
            if_req = 1'b0; dm_req = 1'b0;
         end
         @(negedge clk);
         if (c >= 25) begin
            n_checks++;
            if (m1_en !== 1'b0) $display("FAIL b2b_dropped_req c%0d: got mem_en %b", c, m1_en);
            else n_pass++;
         end
         if (if1_ack || dm1_ack) begin
            n_checks++;
            if (sb1.size() == 0) $display("FAIL b2b_ack unexpected at c%0d", c);
            else begin
               e = sb1.pop_front();
               if ((dm1_ack !== e.is_dm) || (if1_ack === dm1_ack) || (c != e.cyc) ||
                   ((e.is_dm ? dm1_rdata : if1_rdata) !== e.rdata))
                  $display("FAIL b2b_ack: got dm=%b if=%b c%0d data %h/%h, want dm=%b c%0d %h",
                           dm1_ack, if1_ack, c, dm1_rdata, if1_rdata, e.is_dm, e.cyc, e.rdata);
               else n_pass++;
            end
            if (dm1_ack) dn++;
            if (if1_ack) fn++;
         end
      end
      n_checks++;
      if (sb1.size() != 0) begin
         $display("FAIL b2b_missing_ack: got %0d pending, want 0", sb1.size());
         sb1.delete();
      end else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      exp_t e;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            if_req = 1'b1; if_addr = 32'h80;
            sb3.push_back('{1'b0, f_mem(32'h80), 9});
         end
         if (c == 3) rst = 1'b1;
         if (c == 4) rst = 1'b0;
         if (c == 10) if_req = 1'b0;
         @(negedge clk);
         if (c == 4 || c == 5) begin
            n_checks++;
            if (m3_en !== (c == 5))
               $display("FAIL rstmid_mem_en c%0d: got %b want %b", c, m3_en, c == 5);
            else n_pass++;
         end
         if (c == 4) begin
            n_checks++;
            if (if3_rdata !== 32'h0) $display("FAIL rstmid_rdata: got %h want 0", if3_rdata);
            else n_pass++;
         end
         if (if3_ack || dm3_ack) begin
            n_checks++;
            if (sb3.size() == 0) $display("FAIL rstmid_ack unexpected at c%0d", c);
            else begin
               e = sb3.pop_front();
               if ((dm3_ack !== e.is_dm) || (if3_ack === dm3_ack) || (c != e.cyc) ||
                   ((e.is_dm ? dm3_rdata : if3_rdata) !== e.rdata))
                  $display("FAIL rstmid_ack: got dm=%b if=%b c%0d data %h/%h, want dm=%b c%0d %h",
                           dm3_ack, if3_ack, c, dm3_rdata, if3_rdata, e.is_dm, e.cyc, e.rdata);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (sb3.size() != 0) begin
         $display("FAIL rstmid_missing_ack: got %0d pending, want 0", sb3.size());
         sb3.delete();
      end else n_pass++;
   endtask

   task automatic test_latency3();
      exp_t e;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
            sb3.push_back('{1'b1, f_mem(32'h300), 5});
         end
         if (c == 6) dm_req = 1'b0;
         @(negedge clk);
         n_checks++;
         if (m3_en !== (c == 1))
            $display("FAIL lat3_mem_en c%0d: got %b want %b", c, m3_en, c == 1);
         else n_pass++;
         if (c == 4) begin
            n_checks++;
            if (dm3_rdata !== 32'h0) $display("FAIL lat3_early_capture: got %h want 0", dm3_rdata);
            else n_pass++;
         end
         if (if3_ack || dm3_ack) begin
            n_checks++;
            if (sb3.size() == 0) $display("FAIL lat3_ack unexpected at c%0d", c);
            else begin
               e = sb3.pop_front();
               if ((dm3_ack !== e.is_dm) || (if3_ack === dm3_ack) || (c != e.cyc) ||
                   ((e.is_dm ? dm3_rdata : if3_rdata) !== e.rdata))
                  $display("FAIL lat3_ack: got dm=%b if=%b c%0d data %h/%h, want dm=%b c%0d %h",
                           dm3_ack, if3_ack, c, dm3_rdata, if3_rdata, e.is_dm, e.cyc, e.rdata);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (sb3.size() != 0) begin
         $display("FAIL lat3_missing_ack: got %0d pending, want 0", sb3.size());
         sb3.delete();
      end else n_pass++;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      test_reset();
      test_fetch_read();
      test_contention();
      test_write();
      test_back_to_back();
      test_reset_mid_read();
      test_latency3();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               n_pass, n_checks);
      $fatal(1);
   end

endmodule
